// File: rtl/rom_select_ctrl.sv
// -----------------------------------------------------------------------------
// rom_select_ctrl
//
// Front-panel ROM selector feeding the memory loader's reload/index inputs.
// The raw select button (active-low, pulled up) is synchronised and
// debounced, then classified as a short press or a long press:
//   short press : advance to the next ROM slot (mod NUM_ROMS) and reload it
//   long press  : reload the current slot
// After any reload request, further presses are ignored until the loader has
// dropped load_done and raised it again, and the button is released.
//
// Optional feature macro: ROMSEL_BOOT_LOAD_EN
//   defined   : reset enters BOOT; the first cycle out of reset pulses reload
//               with index 0, so slot 0 auto-loads at power-up.
//   undefined : reset enters IDLE; nothing loads until the first press.
//
// Ports
//   clock      in   1  system clock, all logic on posedge
//   reset_n    in   1  synchronous, active-low reset
//   btn_in     in   1  raw button pin, 0 = pressed, asynchronous to clock
//   load_done  in   1  loader status, 1 = ROM resident, 0 = load in progress
//   reload     out  1  one-cycle pulse requesting a (re)load of slot index
//   index      out  4  selected ROM slot, stable while reload is high
//   busy       out  1  high whenever the FSM is not IDLE
// -----------------------------------------------------------------------------
module rom_select_ctrl #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter logic [23:0] LONG_CYCLES     = 24'd6000000,
    parameter int unsigned NUM_ROMS        = 4
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       btn_in,
    input  logic       load_done,
    output logic       reload,
    output logic [3:0] index,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESS     = 2'd1,
        WAIT_LOAD = 2'd2,
        BOOT      = 2'd3
    } state_t;

`ifdef ROMSEL_BOOT_LOAD_EN
    localparam state_t RESET_STATE = BOOT;
`else
    localparam state_t RESET_STATE = IDLE;
`endif

    localparam logic [3:0] LAST_IDX = 4'(NUM_ROMS - 1);

    logic        sync1_q;
    logic        sync2_q;
    logic        btn_s;
    logic        btn_db_q,   btn_db_d;
    logic [15:0] db_cnt_q,   db_cnt_d;
    state_t      state_q,    state_d;
    logic [23:0] hold_cnt_q, hold_cnt_d;
    logic        saw_low_q,  saw_low_d;
    logic        reload_q,   reload_d;
    logic [3:0]  index_q,    index_d;

    // Only the second synchroniser stage feeds any logic.
    assign btn_s = sync2_q;

    // Debounce: btn_db follows btn_s only after DEBOUNCE_CYCLES consecutive
    // cycles of disagreement; any agreement restarts the count.
    always_comb begin
        btn_db_d = btn_db_q;
        db_cnt_d = 16'd0;
        if (btn_s == btn_db_q) begin
            db_cnt_d = 16'd0;
        end else if (db_cnt_q == (DEBOUNCE_CYCLES - 16'd1)) begin
            btn_db_d = btn_s;
            db_cnt_d = 16'd0;
        end else begin
            db_cnt_d = db_cnt_q + 16'd1;
        end
    end

    // Press classification and load handshake; reload_d is a pulse that is
    // only raised on the transition into WAIT_LOAD.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        saw_low_d  = saw_low_q;
        reload_d   = 1'b0;
        index_d    = index_q;
        case (state_q)
            IDLE: begin
                if (!btn_db_q) begin
                    state_d    = PRESS;
                    hold_cnt_d = 24'd0;
                end else begin
                    state_d = IDLE;
                end
            end
            PRESS: begin
                // Threshold is checked first so a release landing on the
                // threshold cycle still counts as a long press.
                if (hold_cnt_q == (LONG_CYCLES - 24'd1)) begin
                    reload_d  = 1'b1;
                    saw_low_d = 1'b0;
                    state_d   = WAIT_LOAD;
                end else if (btn_db_q) begin
                    index_d   = (index_q == LAST_IDX) ? 4'd0 : (index_q + 4'd1);
                    reload_d  = 1'b1;
                    saw_low_d = 1'b0;
                    state_d   = WAIT_LOAD;
                end else begin
                    hold_cnt_d = hold_cnt_q + 24'd1;
                end
            end
            WAIT_LOAD: begin
                // Leave only after a full low->high load_done cycle and with
                // the button released, so a held long press cannot retrigger.
                if (saw_low_q && load_done && btn_db_q) begin
                    state_d = IDLE;
                end else if (!load_done) begin
                    saw_low_d = 1'b1;
                end else begin
                    state_d = WAIT_LOAD;
                end
            end
`ifdef ROMSEL_BOOT_LOAD_EN
            BOOT: begin
                reload_d  = 1'b1;
                index_d   = 4'd0;
                saw_low_d = 1'b0;
                state_d   = WAIT_LOAD;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // All state registers, with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            btn_db_q   <= 1'b1;
            db_cnt_q   <= 16'd0;
            state_q    <= RESET_STATE;
            hold_cnt_q <= 24'd0;
            saw_low_q  <= 1'b0;
            reload_q   <= 1'b0;
            index_q    <= 4'd0;
        end else begin
            sync1_q    <= btn_in;
            sync2_q    <= sync1_q;
            btn_db_q   <= btn_db_d;
            db_cnt_q   <= db_cnt_d;
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            saw_low_q  <= saw_low_d;
            reload_q   <= reload_d;
            index_q    <= index_d;
        end
    end

    assign reload = reload_q;
    assign index  = index_q;
    assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_rom_select_ctrl.sv
module tb_rom_select_ctrl;

    localparam int DB = 4;
    localparam int LP = 20;
    localparam int NR = 3;
`ifdef ROMSEL_BOOT_LOAD_EN
    localparam bit BOOT_EN = 1'b1;
`else
    localparam bit BOOT_EN = 1'b0;
`endif

    logic       clock;
    logic       reset_n;
    logic       btn_in;
    logic       load_done;
    logic       reload;
    logic [3:0] index;
    logic       busy;

    int         n_assert;
    int         n_fail;
    int         cyc;
    logic       reload_prev;
    int         pulse_cyc[$];
    logic [3:0] pulse_idx[$];

    // reference model state
    logic [3:0] exp_index;
    int         exp_reloads;

    rom_select_ctrl #(
        .DEBOUNCE_CYCLES(16'd4),
        .LONG_CYCLES    (24'd20),
        .NUM_ROMS       (3)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .btn_in   (btn_in),
        .load_done(load_done),
        .reload   (reload),
        .index    (index),
        .busy     (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Records every reload pulse (cycle and index) and checks it is one cycle wide.
    initial reload_prev = 1'b0;
    always @(negedge clock) begin
        if (reload === 1'b1) begin
            pulse_cyc.push_back(cyc);
            pulse_idx.push_back(index);
            n_assert++;
            assert (reload_prev === 1'b0) else begin
                n_fail++;
                $error("FAIL pulse_width: reload high on consecutive cycles at cycle %0d (required single cycle)", cyc);
            end
        end
        reload_prev <= reload;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not reach the end of the sequence");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // After reset is released: with the boot feature, slot 0 loads at once.
    task automatic after_reset();
        if (BOOT_EN) begin
            step(1);
            check("boot_reload", 32'(reload), 32'd1);
            check("boot_index", 32'(index), 32'd0);
            check("boot_busy", 32'(busy), 32'd1);
            exp_reloads++;
            load_done = 1'b0;
            step(3);
            load_done = 1'b1;
            step(3);
            check("boot_busy_done", 32'(busy), 32'd0);
        end else begin
            step(6);
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_pulses", 32'(pulse_cyc.size()), 32'(exp_reloads));
        end
    endtask

    // Holds the button for len cycles from IDLE and checks the outcome against
    // the rules: len < DB is a glitch, len >= LP is long, otherwise short.
    // The debounced edge lags the pin by DB+2 cycles and the FSM adds one more.
    task automatic press(input int len);
        int start;
        int held;
        int exp_cyc;
        @(posedge clock);
        #1;
        btn_in = 1'b0;
        start  = cyc;
        step(len);
        btn_in = 1'b1;
        step(DB + LP + 12);
        if (len >= DB) begin
            held = (len < LP) ? len : LP;
            if (len < LP) exp_index = (exp_index == 4'(NR - 1)) ? 4'd0 : exp_index + 4'd1;
            exp_reloads++;
            exp_cyc = start + DB + 3 + held;
            check("press_pulses", 32'(pulse_cyc.size()), 32'(exp_reloads));
            if (pulse_cyc.size() > 0) begin
                check("press_pulse_cycle", 32'(pulse_cyc[pulse_cyc.size() - 1]), 32'(exp_cyc));
                check("press_pulse_index", 32'(pulse_idx[pulse_idx.size() - 1]), 32'(exp_index));
            end
            check("press_busy", 32'(busy), 32'd1);
        end else begin
            check("glitch_pulses", 32'(pulse_cyc.size()), 32'(exp_reloads));
            check("glitch_busy", 32'(busy), 32'd0);
        end
        check("press_index", 32'(index), 32'(exp_index));
        check("press_reload_low", 32'(reload), 32'd0);
    endtask

    // A press while waiting for the loader must be ignored entirely.
    task automatic lockout_press(input int len);
        btn_in = 1'b0;
        step(len);
        btn_in = 1'b1;
        step(DB + LP + 12);
        check("lock_pulses", 32'(pulse_cyc.size()), 32'(exp_reloads));
        check("lock_index", 32'(index), 32'(exp_index));
        check("lock_busy", 32'(busy), 32'd1);
    endtask

    task automatic load_cycle(input int low_len);
        load_done = 1'b0;
        step(low_len);
        check("busy_loading", 32'(busy), 32'd1);
        load_done = 1'b1;
        step(3);
        check("busy_after_load", 32'(busy), 32'd0);
    endtask

    initial begin
        int len;
        n_assert    = 0;
        n_fail      = 0;
        exp_index   = 4'd0;
        exp_reloads = 0;
        reset_n     = 1'b0;
        btn_in      = 1'b1;
        load_done   = 1'b1;
        step(3);
        check("rst_reload", 32'(reload), 32'd0);
        check("rst_index", 32'(index), 32'd0);
        check("rst_busy", 32'(busy), 32'(BOOT_EN));
        reset_n = 1'b1;
        after_reset();

        // glitch, then short presses through the wrap
        press(3);
        press(10);
        load_cycle(5);
        press(7);
        load_cycle(2);
        press(12);
        load_cycle(3);
        press(4);
        load_cycle(1);
        press(19);
        load_cycle(4);

        // long press at index 2, and release exactly at the threshold
        press(40);
        load_cycle(5);
        press(20);
        load_cycle(3);

        // lockout, and a loader that never drops load_done
        press(6);
        lockout_press(8);
        step(50);
        check("stuck_busy", 32'(busy), 32'd1);
        check("stuck_pulses", 32'(pulse_cyc.size()), 32'(exp_reloads));
        load_cycle(5);

        // reset in the middle of a press
        press(9);
        load_cycle(2);
        btn_in = 1'b0;
        step(10);
        check("midpress_busy", 32'(busy), 32'd1);
        reset_n = 1'b0;
        btn_in  = 1'b1;
        step(1);
        check("midrst_reload", 32'(reload), 32'd0);
        check("midrst_index", 32'(index), 32'd0);
        check("midrst_busy", 32'(busy), 32'(BOOT_EN));
        exp_index = 4'd0;
        reset_n   = 1'b1;
        after_reset();
        check("midrst_pulses", 32'(pulse_cyc.size()), 32'(exp_reloads));

        // randomized presses
        for (int t = 0; t < 16; t++) begin
            step($urandom_range(1, 5));
            len = $urandom_range(1, 30);
            press(len);
            if (len >= DB) begin
                if ($urandom_range(0, 1) == 1) lockout_press($urandom_range(4, 12));
                load_cycle($urandom_range(1, 6));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
